dma_channel_regfile: RTL and testbench

//  Parametrised per-channel register file and address/count engine for the DMA controller.

---
 rtl/dma_channel_regfile.sv | 233 +++++++++++++++++++++++
 tb/tb_dma_channel_regfile.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_channel_regfile.sv
// DMA per-channel register file with byte-wide CPU access and an
// address/count service engine (start, step, terminal count, write-back).
module dma_channel_regfile #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 16,
  parameter int CHANNELS = 4,
  parameter int MODE_W   = 4,
  localparam int NBYTES  = ADDR_W / DATA_W,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int PTR_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [2:0]        reg_sel,
  input  logic [CH_W-1:0]   reg_ch,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              wr_err,
  input  logic              svc_start,
  input  logic [CH_W-1:0]   svc_ch,
  input  logic              xfer_step,
  input  logic              svc_end,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy,
  output logic              tc
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACT  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [ADDR_W-1:0] base_addr_q [CHANNELS];
  logic [ADDR_W-1:0] base_addr_d [CHANNELS];
  logic [ADDR_W-1:0] cur_addr_q  [CHANNELS];
  logic [ADDR_W-1:0] cur_addr_d  [CHANNELS];
  logic [ADDR_W-1:0] base_cnt_q  [CHANNELS];
  logic [ADDR_W-1:0] base_cnt_d  [CHANNELS];
  logic [ADDR_W-1:0] cur_cnt_q   [CHANNELS];
  logic [ADDR_W-1:0] cur_cnt_d   [CHANNELS];
  logic [MODE_W-1:0] mode_q      [CHANNELS];
  logic [MODE_W-1:0] mode_d      [CHANNELS];

  logic [CHANNELS-1:0] tc_flag_q, tc_flag_d, flag_set;
  logic [PTR_W-1:0]    ptr_q, ptr_d, ptr_nxt;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_err_q, wr_err_d;
  logic                tc_q, tc_d;
  logic [ADDR_W-1:0]   temp_addr_q, temp_addr_d;
  logic [ADDR_W-1:0]   temp_cnt_q, temp_cnt_d;
  logic [1:0]          state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                hit_q, hit_d;
  logic                flag_clr, mclr, blocked, last;

  assign busy     = (state_q != S_IDLE);
  assign mem_addr = temp_addr_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign wr_err   = wr_err_q;
  assign tc       = tc_q;
  assign ptr_nxt  = (ptr_q == PTR_W'(NBYTES - 1)) ? '0 : ptr_q + PTR_W'(1);

  always_comb begin
    base_addr_d = base_addr_q;
    cur_addr_d  = cur_addr_q;
    base_cnt_d  = base_cnt_q;
    cur_cnt_d   = cur_cnt_q;
    mode_d      = mode_q;
    ptr_d       = ptr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    wr_err_d    = 1'b0;
    tc_d        = 1'b0;
    temp_addr_d = temp_addr_q;
    temp_cnt_d  = temp_cnt_q;
    state_d     = state_q;
    ch_d        = ch_q;
    hit_d       = hit_q;
    flag_set    = '0;
    flag_clr    = 1'b0;
    mclr        = 1'b0;
    last        = (temp_cnt_q == '0);
    blocked     = busy && (reg_sel <= 3'd2) && (reg_ch == ch_q);

    unique case (state_q)
      S_IDLE: begin
        if (svc_start) begin
          state_d     = S_ACT;
          ch_d        = svc_ch;
          hit_d       = 1'b0;
          temp_addr_d = cur_addr_q[svc_ch];
          temp_cnt_d  = cur_cnt_q[svc_ch];
        end
      end
      S_ACT: begin
        if (xfer_step) begin
          temp_addr_d = mode_q[ch_q][0] ? temp_addr_q - ADDR_W'(1)
                                        : temp_addr_q + ADDR_W'(1);
          temp_cnt_d  = temp_cnt_q - ADDR_W'(1);
          if (last) begin
            tc_d           = 1'b1;
            flag_set[ch_q] = 1'b1;
            hit_d          = 1'b1;
            state_d        = S_WB;
          end
        end
        if (svc_end) state_d = S_WB;
      end
      S_WB: begin
        // Autoinit reloads only when the service ended on terminal count
        if (hit_q && mode_q[ch_q][1]) begin
          cur_addr_d[ch_q] = base_addr_q[ch_q];
          cur_cnt_d[ch_q]  = base_cnt_q[ch_q];
        end else begin
          cur_addr_d[ch_q] = temp_addr_q;
          cur_cnt_d[ch_q]  = temp_cnt_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_en) begin
      if (blocked) begin
        wr_err_d = 1'b1;
      end else begin
        unique case (reg_sel)
          3'd0: begin
            base_addr_d[reg_ch][ptr_q*DATA_W +: DATA_W] = wr_data;
            cur_addr_d[reg_ch][ptr_q*DATA_W +: DATA_W]  = wr_data;
            ptr_d = ptr_nxt;
          end
          3'd1: begin
            base_cnt_d[reg_ch][ptr_q*DATA_W +: DATA_W] = wr_data;
            cur_cnt_d[reg_ch][ptr_q*DATA_W +: DATA_W]  = wr_data;
            ptr_d = ptr_nxt;
          end
          3'd2:    mode_d[reg_ch] = MODE_W'(wr_data);
          3'd4:    ptr_d = '0;
          3'd5:    mclr = 1'b1;
          default: ;
        endcase
      end
    end else if (rd_en) begin
      rd_valid_d = 1'b1;
      unique case (reg_sel)
        3'd0: begin
          rd_data_d = cur_addr_q[reg_ch][ptr_q*DATA_W +: DATA_W];
          ptr_d     = ptr_nxt;
        end
        3'd1: begin
          rd_data_d = cur_cnt_q[reg_ch][ptr_q*DATA_W +: DATA_W];
          ptr_d     = ptr_nxt;
        end
        3'd2: rd_data_d = DATA_W'(mode_q[reg_ch]);
        3'd3: begin
          rd_data_d = DATA_W'(tc_flag_q);
          flag_clr  = 1'b1;
        end
        default: rd_data_d = '0;
      endcase
    end

    tc_flag_d = (flag_clr ? '0 : tc_flag_q) | flag_set;

    // Master clear spares an in-flight service so it can finish cleanly
    if (mclr) begin
      for (int i = 0; i < CHANNELS; i++) begin
        base_addr_d[i] = '0;
        cur_addr_d[i]  = '0;
        base_cnt_d[i]  = '0;
        cur_cnt_d[i]   = '0;
        mode_d[i]      = '0;
      end
      tc_flag_d = '0;
      ptr_d     = '0;
      rd_data_d = '0;
      tc_d      = 1'b0;
      if (!busy) begin
        state_d     = S_IDLE;
        temp_addr_d = '0;
        temp_cnt_d  = '0;
        ch_d        = '0;
        hit_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < CHANNELS; i++) begin
        base_addr_q[i] <= '0;
        cur_addr_q[i]  <= '0;
        base_cnt_q[i]  <= '0;
        cur_cnt_q[i]   <= '0;
        mode_q[i]      <= '0;
      end
      tc_flag_q   <= '0;
      ptr_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      wr_err_q    <= 1'b0;
      tc_q        <= 1'b0;
      temp_addr_q <= '0;
      temp_cnt_q  <= '0;
      state_q     <= S_IDLE;
      ch_q        <= '0;
      hit_q       <= 1'b0;
    end else begin
      base_addr_q <= base_addr_d;
      cur_addr_q  <= cur_addr_d;
      base_cnt_q  <= base_cnt_d;
      cur_cnt_q   <= cur_cnt_d;
      mode_q      <= mode_d;
      tc_flag_q   <= tc_flag_d;
      ptr_q       <= ptr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      wr_err_q    <= wr_err_d;
      tc_q        <= tc_d;
      temp_addr_q <= temp_addr_d;
      temp_cnt_q  <= temp_cnt_d;
      state_q     <= state_d;
      ch_q        <= ch_d;
      hit_q       <= hit_d;
    end
  end

endmodule

// File: tb/tb_dma_channel_regfile.sv
// Bench for dma_channel_regfile: directed literal checks plus random
// traffic compared every cycle against a transaction-level model.
module tb_dma_channel_regfile;

  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int NCH = 4;
  localparam int MW  = 4;
  localparam int CHW = 2;
  localparam int NB  = AW / DW;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          wr_en, rd_en;
  logic [2:0]    reg_sel;
  logic [CHW-1:0] reg_ch, svc_ch;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_valid, wr_err;
  logic          svc_start, xfer_step, svc_end;
  logic [AW-1:0] mem_addr;
  logic          busy, tc;

  always #5 CLK = ~CLK;

  dma_channel_regfile #(
    .DATA_W(DW), .ADDR_W(AW), .CHANNELS(NCH), .MODE_W(MW)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .wr_en(wr_en), .rd_en(rd_en), .reg_sel(reg_sel), .reg_ch(reg_ch),
    .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_err(wr_err), .svc_start(svc_start), .svc_ch(svc_ch),
    .xfer_step(xfer_step), .svc_end(svc_end), .mem_addr(mem_addr),
    .busy(busy), .tc(tc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: channel registers as plain arrays, service as
  // a running word pointer and remaining count
  logic [AW-1:0] m_base_a [NCH];
  logic [AW-1:0] m_cur_a  [NCH];
  logic [AW-1:0] m_base_c [NCH];
  logic [AW-1:0] m_cur_c  [NCH];
  logic [MW-1:0] m_mode   [NCH];
  logic [NCH-1:0] m_flag;
  int            m_ptr, m_ch;
  bit            m_busy, m_wb, m_hit;
  logic [AW-1:0] m_ta, m_tc;
  logic [DW-1:0] e_rd_data;
  bit            e_rd_valid, e_wr_err, e_tc;

  task automatic m_clear(input bit full);
    for (int i = 0; i < NCH; i++) begin
      m_base_a[i] = 0; m_cur_a[i] = 0;
      m_base_c[i] = 0; m_cur_c[i] = 0;
      m_mode[i] = 0;
    end
    m_flag = 0; m_ptr = 0; e_rd_data = 0; e_tc = 0;
    if (full) begin
      m_busy = 0; m_wb = 0; m_hit = 0; m_ch = 0; m_ta = 0; m_tc = 0;
    end
  endtask

  always @(posedge CLK) begin : model
    logic [NCH-1:0] set_f;
    bit was_busy, clr, last;
    int old_ch, k;
    e_tc = 0; e_wr_err = 0; e_rd_valid = 0; set_f = 0; clr = 0;
    if (RESET) begin
      m_clear(1);
    end else begin
      was_busy = m_busy; old_ch = m_ch; k = m_ptr;
      if (rd_en && !wr_en) begin
        e_rd_valid = 1;
        case (reg_sel)
          3'd0: e_rd_data = DW'(m_cur_a[reg_ch] >> (DW * k));
          3'd1: e_rd_data = DW'(m_cur_c[reg_ch] >> (DW * k));
          3'd2: e_rd_data = DW'(m_mode[reg_ch]);
          3'd3: begin e_rd_data = DW'(m_flag); clr = 1; end
          default: e_rd_data = 0;
        endcase
        if (reg_sel <= 3'd1) m_ptr = (m_ptr + 1) % NB;
      end
      if (m_wb) begin
        if (m_hit && m_mode[m_ch][1]) begin
          m_cur_a[m_ch] = m_base_a[m_ch]; m_cur_c[m_ch] = m_base_c[m_ch];
        end else begin
          m_cur_a[m_ch] = m_ta; m_cur_c[m_ch] = m_tc;
        end
        m_busy = 0; m_wb = 0;
      end else if (m_busy) begin
        if (xfer_step) begin
          last = (m_tc == 0);
          m_ta = m_mode[m_ch][0] ? m_ta - 1 : m_ta + 1;
          m_tc = m_tc - 1;
          if (last) begin e_tc = 1; set_f[m_ch] = 1; m_hit = 1; m_wb = 1; end
        end
        if (svc_end && !m_wb) begin m_hit = 0; m_wb = 1; end
      end else if (svc_start) begin
        m_busy = 1; m_hit = 0; m_ch = int'(svc_ch);
        m_ta = m_cur_a[svc_ch]; m_tc = m_cur_c[svc_ch];
      end
      m_flag = (clr ? '0 : m_flag) | set_f;
      if (wr_en) begin
        if (was_busy && reg_sel <= 3'd2 && int'(reg_ch) == old_ch) begin
          e_wr_err = 1;
        end else begin
          case (reg_sel)
            3'd0: begin
              m_base_a[reg_ch][DW*k +: DW] = wr_data;
              m_cur_a[reg_ch][DW*k +: DW] = wr_data;
              m_ptr = (m_ptr + 1) % NB;
            end
            3'd1: begin
              m_base_c[reg_ch][DW*k +: DW] = wr_data;
              m_cur_c[reg_ch][DW*k +: DW] = wr_data;
              m_ptr = (m_ptr + 1) % NB;
            end
            3'd2: m_mode[reg_ch] = wr_data[MW-1:0];
            3'd4: m_ptr = 0;
            3'd5: m_clear(!was_busy);
            default: ;
          endcase
        end
      end
    end
  end

  always @(negedge CLK) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("tc", 32'(tc), 32'(e_tc));
    chk("wr_err", 32'(wr_err), 32'(e_wr_err));
    chk("rd_valid", 32'(rd_valid), 32'(e_rd_valid));
    if (e_rd_valid) chk("rd_data", 32'(rd_data), 32'(e_rd_data));
    chk("mem_addr", 32'(mem_addr), 32'(m_ta));
  end

  task automatic idle();
    RESET = 0; wr_en = 0; rd_en = 0; reg_sel = 0; reg_ch = 0; wr_data = 0;
    svc_start = 0; svc_ch = 0; xfer_step = 0; svc_end = 0;
  endtask

  task automatic cyc();
    @(posedge CLK); #1;
    idle();
  endtask

  task automatic wr(input logic [2:0] s, input logic [CHW-1:0] ch,
                    input logic [DW-1:0] d);
    wr_en = 1; reg_sel = s; reg_ch = ch; wr_data = d;
    cyc();
  endtask

  task automatic rd(input logic [2:0] s, input logic [CHW-1:0] ch,
                    input logic [DW-1:0] e, input string nm);
    rd_en = 1; reg_sel = s; reg_ch = ch;
    cyc();
    chk({nm, "_vld"}, 32'(rd_valid), 32'd1);
    chk(nm, 32'(rd_data), 32'(e));
  endtask

  task automatic start(input logic [CHW-1:0] ch);
    svc_start = 1; svc_ch = ch;
    cyc();
  endtask

  initial begin
    idle();
    RESET = 1;
    cyc();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem", 32'(mem_addr), 0);
    chk("rst_rdv", 32'(rd_valid), 0);

    wr(4, 0, 8'h00);
    wr(0, 2, 8'h34); wr(0, 2, 8'h12);
    wr(1, 2, 8'h02); wr(1, 2, 8'h00);
    rd(0, 2, 8'h34, "ch2_a0"); rd(0, 2, 8'h12, "ch2_a1");

    start(2);
    chk("ch2_mem0", 32'(mem_addr), 32'h1234);
    xfer_step = 1; cyc();
    chk("ch2_mem1", 32'(mem_addr), 32'h1235);
    chk("ch2_tc1", 32'(tc), 0);
    xfer_step = 1; cyc();
    chk("ch2_mem2", 32'(mem_addr), 32'h1236);
    xfer_step = 1; cyc();
    chk("ch2_tc3", 32'(tc), 1);
    cyc();
    chk("ch2_idle", 32'(busy), 0);
    rd(0, 2, 8'h37, "ch2_cur_a0"); rd(0, 2, 8'h12, "ch2_cur_a1");
    rd(1, 2, 8'hFF, "ch2_cur_c0"); rd(1, 2, 8'hFF, "ch2_cur_c1");

    wr(2, 1, 8'h03);
    wr(0, 1, 8'h00); wr(0, 1, 8'h01);
    wr(1, 1, 8'h01); wr(1, 1, 8'h00);
    start(1);
    chk("ch1_mem0", 32'(mem_addr), 32'h0100);
    xfer_step = 1; cyc();
    chk("ch1_mem1", 32'(mem_addr), 32'h00FF);
    xfer_step = 1; cyc();
    chk("ch1_tc", 32'(tc), 1);
    cyc();
    rd(0, 1, 8'h00, "ch1_ai_a0"); rd(0, 1, 8'h01, "ch1_ai_a1");
    rd(1, 1, 8'h01, "ch1_ai_c0"); rd(1, 1, 8'h00, "ch1_ai_c1");
    rd(2, 1, 8'h03, "ch1_mode");

    rd(3, 0, 8'h06, "stat1"); rd(3, 0, 8'h00, "stat2");

    wr(1, 0, 8'h00); wr(1, 0, 8'h00);
    start(0);
    xfer_step = 1; rd_en = 1; reg_sel = 3; cyc();
    chk("stat_race_rd", 32'(rd_data), 0);
    chk("stat_race_tc", 32'(tc), 1);
    cyc();
    rd(3, 0, 8'h01, "stat_kept"); rd(3, 0, 8'h00, "stat_clr");

    start(3);
    wr(0, 3, 8'hAB);
    chk("wr_err_pulse", 32'(wr_err), 1);
    svc_end = 1; cyc();
    chk("wr_err_once", 32'(wr_err), 0);
    cyc();
    rd(0, 3, 8'h00, "ch3_a0"); rd(0, 3, 8'h00, "ch3_a1");

    start(2);
    chk("mid_busy", 32'(busy), 1);
    RESET = 1; cyc();
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_mem", 32'(mem_addr), 0);
    rd(0, 2, 8'h00, "rst_a0"); rd(0, 2, 8'h00, "rst_a1");
    rd(2, 1, 8'h00, "rst_mode");

    wr(0, 0, 8'hAA); wr(4, 0, 8'h00);
    wr(0, 0, 8'h11); wr(0, 0, 8'h22);
    rd(0, 0, 8'h11, "ff_b0"); rd(0, 0, 8'h22, "ff_b1");

    for (int n = 0; n < 4000; n++) begin
      int op;
      op = int'($urandom % 10);
      reg_ch = CHW'($urandom);
      wr_data = DW'($urandom);
      if (op < 3) begin
        wr_en = 1;
        reg_sel = 3'($urandom % 5);
        if ($urandom % 24 == 0) reg_sel = 3'd5;
        if (reg_sel == 3'd1 && $urandom % 2 == 0) wr_data = DW'($urandom % 3);
        if ($urandom % 8 == 0) rd_en = 1;
      end else if (op < 6) begin
        rd_en = 1;
        reg_sel = 3'($urandom % 4);
      end
      svc_start = ($urandom % 6 == 0);
      svc_ch = CHW'($urandom);
      xfer_step = ($urandom % 2 == 0);
      svc_end = ($urandom % 20 == 0);
      if ($urandom % 700 == 0) RESET = 1;
      cyc();
    end

    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
